motion_sequencer: RTL and testbench

//  Timed motion-command sequencer that drives the 3-bit wheel-state code consumed by the wheels H-bridge stage.

---
 rtl/motion_sequencer.sv | 159 +++++++++++++++
 tb/tb_motion_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_sequencer.sv
// Timed motion-command sequencer driving the wheel-state code of the H-bridge stage.
// Holds each motion for an exact tick count, inserts STOP dead time, aborts on obstacle.
module motion_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int TW         = 16,
    parameter int DEAD_TICKS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [TW-1:0] cmd_ticks,
    input  logic          obstacle,
    input  logic          abort,
    output logic [2:0]    state,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          err
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [2:0] OP_STOP = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_RUN,
        S_HALT
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    state_q, state_d;
    logic [2:0]    last_q, last_d;
    logic          done_q, done_d;
    logic          abt_q, abt_d;
    logic          err_q, err_d;
    logic          obs_m_q, obs_s_q;

    logic tick;
    logic op_fwd;
    logic cmd_fwd;

    assign tick    = (pre_q == PW'(TICK_DIV - 1));
    assign op_fwd  = (op_q < 3'd3);
    assign cmd_fwd = (cmd_op < 3'd3);

    always_comb begin
        fsm_d   = fsm_q;
        pre_d   = '0;
        cnt_d   = cnt_q;
        ticks_d = ticks_q;
        op_d    = op_q;
        state_d = state_q;
        last_d  = last_q;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        err_d   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                state_d = OP_STOP;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ticks_d = cmd_ticks;
                    if (cmd_op[2:1] == 2'b11) begin
                        err_d = 1'b1;
                    end else if (cmd_ticks == '0 || cmd_op == OP_STOP) begin
                        done_d = 1'b1;
                        last_d = OP_STOP;
                    end else if (cmd_fwd && obs_s_q) begin
                        abt_d  = 1'b1;
                        last_d = OP_STOP;
                        fsm_d  = S_HALT;
                    end else if (DEAD_TICKS > 0 && cmd_op != last_q
                                 && last_q != OP_STOP) begin
                        cnt_d = TW'(DEAD_TICKS);
                        fsm_d = S_DEAD;
                    end else begin
                        cnt_d   = cmd_ticks;
                        state_d = cmd_op;
                        fsm_d   = S_RUN;
                    end
                end
            end
            S_DEAD, S_RUN: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (abort || (obs_s_q && op_fwd)) begin
                    state_d = OP_STOP;
                    abt_d   = 1'b1;
                    last_d  = OP_STOP;
                    fsm_d   = abort ? S_IDLE : S_HALT;
                end else if (tick) begin
                    if (cnt_q > TW'(1)) begin
                        cnt_d = cnt_q - TW'(1);
                    end else if (fsm_q == S_DEAD) begin
                        cnt_d   = ticks_q;
                        state_d = op_q;
                        fsm_d   = S_RUN;
                    end else begin
                        state_d = OP_STOP;
                        done_d  = 1'b1;
                        last_d  = op_q;
                        fsm_d   = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                state_d = OP_STOP;
                if (!obs_s_q) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            ticks_q <= '0;
            op_q    <= OP_STOP;
            state_q <= OP_STOP;
            last_q  <= OP_STOP;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
            err_q   <= 1'b0;
            obs_m_q <= 1'b0;
            obs_s_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            ticks_q <= ticks_d;
            op_q    <= op_d;
            state_q <= state_d;
            last_q  <= last_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
            err_q   <= err_d;
            obs_m_q <= obstacle;
            obs_s_q <= obs_m_q;
        end
    end

    assign cmd_ready = (fsm_q == S_IDLE);
    assign busy      = (fsm_q != S_IDLE);
    assign state     = state_q;
    assign done      = done_q;
    assign aborted   = abt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: single-command vector table plus
// hand sequences for dead time, obstacle, abort race and reset mid-DEAD.
module tb_motion_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_ticks;
    logic       obstacle;
    logic       abort;
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;

    int total = 0;
    int bad   = 0;

    motion_sequencer #(
        .TICK_DIV  (4),
        .TW        (8),
        .DEAD_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_ticks(cmd_ticks),
        .obstacle (obstacle),
        .abort    (abort),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] ticks;
        logic [2:0] st1;
        logic       err1;
        logic       done1;
        logic       rdy1;
        int         len;
    } vec_t;

    vec_t tbl[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b011;
        cmd_ticks = '0;
        abort     = 1'b0;
        obstacle  = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] t);
        cmd_op    = op;
        cmd_ticks = t;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_motion(input logic [2:0] op, output int n);
        n = 0;
        while (state === op && n < 2000) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        tbl[0] = '{3'b000, 8'd3,   3'b000, 1'b0, 1'b0, 1'b0, 12};
        tbl[1] = '{3'b001, 8'd1,   3'b001, 1'b0, 1'b0, 1'b0, 4};
        tbl[2] = '{3'b100, 8'd2,   3'b100, 1'b0, 1'b0, 1'b0, 8};
        tbl[3] = '{3'b101, 8'd2,   3'b101, 1'b0, 1'b0, 1'b0, 8};
        tbl[4] = '{3'b110, 8'd5,   3'b011, 1'b1, 1'b0, 1'b1, 0};
        tbl[5] = '{3'b111, 8'd1,   3'b011, 1'b1, 1'b0, 1'b1, 0};
        tbl[6] = '{3'b000, 8'd0,   3'b011, 1'b0, 1'b1, 1'b1, 0};
        tbl[7] = '{3'b011, 8'd4,   3'b011, 1'b0, 1'b1, 1'b1, 0};
        tbl[8] = '{3'b010, 8'd255, 3'b010, 1'b0, 1'b0, 1'b0, 1020};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b011;
        cmd_ticks = '0;
        abort     = 1'b0;
        obstacle  = 1'b0;
        step();
        chk("rst_state", state, 3'b011);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, aborted, err}, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            issue(tbl[i].op, tbl[i].ticks);
            chk($sformatf("v%0d_st1", i), state, tbl[i].st1);
            chk($sformatf("v%0d_err", i), err, tbl[i].err1);
            chk($sformatf("v%0d_done", i), done, tbl[i].done1);
            chk($sformatf("v%0d_abt", i), aborted, 0);
            chk($sformatf("v%0d_rdy", i), cmd_ready, tbl[i].rdy1);
            if (tbl[i].len > 0) begin
                wait_motion(tbl[i].op, n);
                chk($sformatf("v%0d_len", i), n, tbl[i].len);
                chk($sformatf("v%0d_done_end", i), done, 1);
                chk($sformatf("v%0d_st_end", i), state, 3'b011);
                step();
                chk($sformatf("v%0d_done_1clk", i), done, 0);
            end else begin
                step();
                chk($sformatf("v%0d_pulse_1clk", i), {done, err}, 0);
                chk($sformatf("v%0d_idle", i), state, 3'b011);
            end
        end

        // FWD then REV: dead gap; REV then FWD: dead gap; FWD then FWD: none
        do_reset();
        issue(3'b000, 8'd2);
        wait_motion(3'b000, n);
        chk("fr_fwd_len", n, 8);
        issue(3'b101, 8'd2);
        n = 0;
        while (state === 3'b011 && busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk("fr_dead_len", n, 8);
        chk("fr_rev_st", state, 3'b101);
        wait_motion(3'b101, n);
        chk("fr_rev_len", n, 8);
        issue(3'b000, 8'd2);
        n = 0;
        while (state === 3'b011 && busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk("rf_dead_len", n, 8);
        wait_motion(3'b000, n);
        chk("rf_fwd_len", n, 8);
        issue(3'b000, 8'd2);
        chk("ff_no_gap", state, 3'b000);
        wait_motion(3'b000, n);
        chk("ff_len", n, 8);

        // obstacle during forward RUN
        do_reset();
        issue(3'b000, 8'd10);
        chk("ob_run", state, 3'b000);
        repeat (4) step();
        obstacle = 1'b1;
        step();
        chk("ob_d1", state, 3'b000);
        step();
        chk("ob_d2", state, 3'b000);
        step();
        chk("ob_stop", state, 3'b011);
        chk("ob_abt", aborted, 1);
        chk("ob_nodone", done, 0);
        chk("ob_busy", busy, 1);
        step();
        chk("ob_abt_1clk", aborted, 0);
        repeat (3) step();
        chk("ob_halt", busy, 1);
        obstacle = 1'b0;
        step();
        step();
        chk("ob_halt_sync", busy, 1);
        step();
        chk("ob_release", cmd_ready, 1);
        chk("ob_release_busy", busy, 0);

        // REV ignores obstacle; forward accept with obstacle goes HALT
        obstacle = 1'b1;
        step();
        step();
        issue(3'b101, 8'd10);
        wait_motion(3'b101, n);
        chk("ob_rev_len", n, 40);
        chk("ob_rev_done", done, 1);
        issue(3'b000, 8'd3);
        chk("ob_acc_abt", aborted, 1);
        chk("ob_acc_st", state, 3'b011);
        chk("ob_acc_busy", busy, 1);
        obstacle = 1'b0;
        repeat (3) step();
        chk("ob_acc_rel", cmd_ready, 1);

        // abort on same cycle as final tick, cmd_valid during RUN ignored
        do_reset();
        issue(3'b000, 8'd1);
        chk("ab_run", state, 3'b000);
        cmd_valid = 1'b1;
        cmd_op    = 3'b101;
        cmd_ticks = 8'd9;
        repeat (3) step();
        chk("ab_ignored_cmd", state, 3'b000);
        chk("ab_ready_low", cmd_ready, 0);
        abort = 1'b1;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("ab_abt", aborted, 1);
        chk("ab_nodone", done, 0);
        chk("ab_st", state, 3'b011);
        chk("ab_idle", cmd_ready, 1);
        step();
        chk("ab_quiet", {done, aborted, err}, 0);
        chk("ab_not_busy", busy, 0);

        // async reset mid-DEAD, next SPIN without dead time
        do_reset();
        issue(3'b000, 8'd1);
        wait_motion(3'b000, n);
        chk("rd_fwd_len", n, 4);
        issue(3'b101, 8'd4);
        step();
        step();
        chk("rd_in_dead", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rd_st", state, 3'b011);
        chk("rd_busy", busy, 0);
        chk("rd_ready", cmd_ready, 1);
        chk("rd_pulses", {done, aborted, err}, 0);
        step();
        rst_n = 1'b1;
        step();
        issue(3'b100, 8'd2);
        chk("rd_spin_direct", state, 3'b100);
        wait_motion(3'b100, n);
        chk("rd_spin_len", n, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
